fifo_status: RTL and testbench

- Parametrised circular-buffer FIFO with occupancy count, programmable almost-full/almost-empty flags, synchronous flush, and sticky overflow/underflow error flags.
- Successor to the basic UART-side FIFO; sits between the UART rx/tx and the BIP debug/loader logic.
- Lets the consumer throttle on thresholds instead of hard full/empty.
- Head word is presented first-word-fall-through.

---
 rtl/fifo_status.sv | 129 ++++++++++++
 tb/tb_fifo_status.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/fifo_status.sv
// fifo_status: circular-buffer FIFO with occupancy count, programmable
// almost-full/almost-empty flags, synchronous flush and sticky error flags.
// The head word is presented first-word-fall-through on r_data.
//
// Ports:
//   CLK, RESET       clock (rising edge) and async active-high reset
//   clr              synchronous flush, wins over wr/rd in the same cycle
//   wr, w_data       write request and data
//   rd               read request (pops the head word)
//   r_data           head-of-queue word, undefined while empty
//   empty, full      no entries / 2**W entries stored
//   almost_empty     count <= AE_TH
//   almost_full      count >= AF_TH
//   count            entries stored, 0..2**W
//   overflow         sticky: write attempted while full
//   underflow        sticky: read attempted while empty
module fifo_status #(
  parameter int B     = 8,
  parameter int W     = 5,
  parameter int AF_TH = 2**W - 2,
  parameter int AE_TH = 2
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         clr,
  input  logic         wr,
  input  logic         rd,
  input  logic [B-1:0] w_data,
  output logic [B-1:0] r_data,
  output logic         empty,
  output logic         full,
  output logic         almost_empty,
  output logic         almost_full,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow
);

  localparam logic [W:0] DEPTH  = (W+1)'(2**W);
  localparam logic [W:0] AF_C   = (W+1)'(AF_TH);
  localparam logic [W:0] AE_C   = (W+1)'(AE_TH);
  localparam logic       AF_RST = (AF_TH == 0);

  logic [B-1:0] mem_q [0:(2**W)-1];

  logic [W-1:0] w_ptr_q, w_ptr_d;
  logic [W-1:0] r_ptr_q, r_ptr_d;
  logic [W:0]   count_q, count_d;
  logic         empty_q, empty_d;
  logic         full_q, full_d;
  logic         ae_q, ae_d;
  logic         af_q, af_d;
  logic         ovf_q, ovf_d;
  logic         udf_q, udf_d;
  logic         wr_acc, rd_acc;

  // Acceptance is judged against the registered flags; a flush cycle
  // accepts nothing so the flushed write never reaches memory.
  always_comb begin
    wr_acc  = wr & ~full_q & ~clr;
    rd_acc  = rd & ~empty_q & ~clr;

    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;

    if (clr) begin
      w_ptr_d = '0;
      r_ptr_d = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (wr_acc) w_ptr_d = w_ptr_q + W'(1);
      if (rd_acc) r_ptr_d = r_ptr_q + W'(1);
      if (wr_acc && !rd_acc)      count_d = count_q + (W+1)'(1);
      else if (rd_acc && !wr_acc) count_d = count_q - (W+1)'(1);
      if (wr && full_q)  ovf_d = 1'b1;
      if (rd && empty_q) udf_d = 1'b1;
    end

    // Flags follow the next count so they line up with count itself.
    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH);
    ae_d    = (count_d <= AE_C);
    af_d    = (count_d >= AF_C);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ae_q    <= 1'b1;
      af_q    <= AF_RST;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ae_q    <= ae_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge CLK) begin
    if (wr_acc) mem_q[w_ptr_q] <= w_data;
  end

  assign r_data       = mem_q[r_ptr_q];
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = ae_q;
  assign almost_full  = af_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_fifo_status.sv
module tb_fifo_status;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       clr = 1'b0;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] w_data = 8'h00;
  logic [7:0] r_data;
  logic       empty, full, almost_empty, almost_full;
  logic [2:0] count;
  logic       overflow, underflow;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         cnt;
    logic       ovf;
    logic       udf;
    logic [7:0] rdat;
    logic       chk_rd;
    string      nm;
  } exp_t;

  exp_t sb_q[$];

  fifo_status #(.B(8), .W(2), .AF_TH(3), .AE_TH(1)) dut (
    .CLK(CLK), .RESET(RESET), .clr(clr), .wr(wr), .rd(rd),
    .w_data(w_data), .r_data(r_data), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input string fld, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s.%s got=0x%0h expected=0x%0h", nm, fld, got, exp);
    end
  endtask

  // Flag expectations come from the bench's thresholds (depth 4, AF 3, AE 1).
  task automatic compare(input exp_t e);
    chk(e.nm, "count", int'(count), e.cnt);
    chk(e.nm, "empty", int'(empty), int'(e.cnt == 0));
    chk(e.nm, "full", int'(full), int'(e.cnt == 4));
    chk(e.nm, "almost_empty", int'(almost_empty), int'(e.cnt <= 1));
    chk(e.nm, "almost_full", int'(almost_full), int'(e.cnt >= 3));
    chk(e.nm, "overflow", int'(overflow), int'(e.ovf));
    chk(e.nm, "underflow", int'(underflow), int'(e.udf));
    if (e.chk_rd) chk(e.nm, "r_data", int'(r_data), int'(e.rdat));
  endtask

  // Monitor: outputs settle after the rising edge; sample on the falling edge.
  initial begin
    forever begin
      @(negedge CLK);
      while (sb_q.size() > 0) compare(sb_q.pop_front());
    end
  end

  task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d,
                      input int ecnt, input logic eo, input logic eu,
                      input logic [7:0] er, input logic ck, input string nm);
    exp_t e;
    @(negedge CLK);
    wr = w; rd = r; clr = c; w_data = d;
    @(posedge CLK);
    e.cnt = ecnt; e.ovf = eo; e.udf = eu; e.rdat = er; e.chk_rd = ck; e.nm = nm;
    sb_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    int   budget;

    #12;
    e.cnt = 0; e.ovf = 0; e.udf = 0; e.rdat = 8'h00; e.chk_rd = 0; e.nm = "reset";
    compare(e);
    @(negedge CLK);
    RESET = 1'b0;

    step(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, "idle");
    step(1, 0, 0, 8'h11, 1, 0, 0, 8'h11, 1, "wr11");
    step(1, 0, 0, 8'h22, 2, 0, 0, 8'h11, 1, "wr22");
    step(1, 0, 0, 8'h33, 3, 0, 0, 8'h11, 1, "wr33");
    step(1, 0, 0, 8'h44, 4, 0, 0, 8'h11, 1, "wr44");
    step(1, 0, 0, 8'h55, 4, 1, 0, 8'h11, 1, "wr_full");
    step(1'b0, 1, 0, 8'h00, 3, 1, 0, 8'h22, 1, "rd1");
    step(1'b0, 1, 0, 8'h00, 2, 1, 0, 8'h33, 1, "rd2");
    step(1'b0, 1, 0, 8'h00, 1, 1, 0, 8'h44, 1, "rd3");
    step(1'b0, 1, 0, 8'h00, 0, 1, 0, 8'h00, 0, "rd4");
    step(1, 1, 0, 8'hA5, 1, 1, 1, 8'hA5, 1, "wrrd_empty");
    step(1, 0, 0, 8'hB1, 2, 1, 1, 8'hA5, 1, "wrB1");
    step(1, 0, 0, 8'hB2, 3, 1, 1, 8'hA5, 1, "wrB2");
    step(1, 0, 0, 8'hB3, 4, 1, 1, 8'hA5, 1, "wrB3");
    step(1, 1, 0, 8'h66, 3, 1, 1, 8'hB1, 1, "wrrd_full");
    step(0, 1, 0, 8'h00, 2, 1, 1, 8'hB2, 1, "rd_to2");
    step(1, 1, 0, 8'h00, 2, 1, 1, 8'hB3, 1, "stream0");
    for (int i = 1; i < 10; i++)
      step(1, 1, 0, 8'(i), 2, 1, 1, 8'(i - 1), 1, $sformatf("stream%0d", i));
    step(0, 1, 0, 8'h00, 1, 1, 1, 8'h09, 1, "drain1");
    step(0, 1, 0, 8'h00, 0, 1, 1, 8'h00, 0, "drain2");
    step(1, 0, 0, 8'hC1, 1, 1, 1, 8'hC1, 1, "wrC1");
    step(1, 0, 0, 8'hC2, 2, 1, 1, 8'hC1, 1, "wrC2");
    step(1, 0, 0, 8'hC3, 3, 1, 1, 8'hC1, 1, "wrC3");
    step(1, 0, 1, 8'hDD, 0, 0, 0, 8'h00, 0, "clr_wr");
    step(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, "post_clr");
    step(1, 0, 0, 8'hE1, 1, 0, 0, 8'hE1, 1, "wrE1");
    step(1, 0, 0, 8'hE2, 2, 0, 0, 8'hE1, 1, "wrE2");
    step(1, 0, 0, 8'hE3, 3, 0, 0, 8'hE1, 1, "wrE3");
    step(1, 0, 0, 8'hE4, 4, 0, 0, 8'hE1, 1, "wrE4");
    step(1, 0, 0, 8'hF0, 4, 1, 0, 8'hE1, 1, "wr_full2");

    @(negedge CLK);
    wr = 1'b0; rd = 1'b0; clr = 1'b0;
    #2 RESET = 1'b1;
    #1;
    e.cnt = 0; e.ovf = 0; e.udf = 0; e.rdat = 8'h00; e.chk_rd = 0; e.nm = "async_reset";
    compare(e);
    @(negedge CLK);
    RESET = 1'b0;
    step(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, "after_reset");
    step(1, 0, 0, 8'h77, 1, 0, 0, 8'h77, 1, "wr77");
    step(0, 0, 0, 8'h00, 1, 0, 0, 8'h77, 1, "hold77");

    budget = 20;
    while (sb_q.size() > 0 && budget > 0) begin
      @(negedge CLK);
      budget--;
    end
    #1;
    if (sb_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout pending=%0d expected=0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
